// File: rtl/plic_prio.sv
// plic_prio: priority interrupt controller with per-source gateways, threshold and claim/complete handshake
//   clk            core clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   irq_i          raw interrupt lines, source k on bit k (1..IRQ_CNT)
//   ie_i           per-source enable
//   edge_i         gateway mode: 1 = rising-edge, 0 = level-high
//   prio_i         priorities, source k at [k*PRIO_W-1 -: PRIO_W]; 0 never interrupts
//   threshold_i    a source interrupts only if its priority exceeds this
//   claim_i        one-cycle pulse claiming the current id_o
//   complete_i     one-cycle completion pulse for complete_id_i
//   complete_id_i  ID being completed
//   irq_o          registered, high when id_o != 0
//   id_o           registered best claimable ID, 0 if none
// Build option: define PLIC_SYNC_EN to pass irq_i through a 2-flop synchroniser.
module plic_prio #(
  parameter int IRQ_CNT = 8,
  parameter int PRIO_W = 3,
  localparam int ID_W = $clog2(IRQ_CNT + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IRQ_CNT:1]          irq_i,
  input  logic [IRQ_CNT:1]          ie_i,
  input  logic [IRQ_CNT:1]          edge_i,
  input  logic [IRQ_CNT*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  input  logic                      claim_i,
  input  logic                      complete_i,
  input  logic [ID_W-1:0]           complete_id_i,
  output logic                      irq_o,
  output logic [ID_W-1:0]           id_o
);
  localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, INFL = 2'd2;
  logic [1:0] st [1:IRQ_CNT];
  logic [IRQ_CNT:1] irq_g, hist;
  logic [ID_W-1:0] win;
  logic [PRIO_W-1:0] win_p;
`ifdef PLIC_SYNC_EN
  logic [IRQ_CNT:1] s1, s2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_i;
      s2 <= s1;
    end
  assign irq_g = s2;
`else
  assign irq_g = irq_i;
`endif
  // Strictly-greater update while scanning upward makes ties resolve to the lowest ID.
  // The source being claimed this cycle is skipped so id_o never repeats it.
  always_comb begin
    win = '0;
    win_p = '0;
    for (int k = 1; k <= IRQ_CNT; k++)
      if (st[k] == PEND && ie_i[k] && prio_i[k*PRIO_W-1 -: PRIO_W] > threshold_i &&
          !(claim_i && id_o == ID_W'(k)) && prio_i[k*PRIO_W-1 -: PRIO_W] > win_p) begin
        win = ID_W'(k);
        win_p = prio_i[k*PRIO_W-1 -: PRIO_W];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 1; k <= IRQ_CNT; k++) st[k] <= IDLE;
      hist <= '0;
      id_o <= '0;
      irq_o <= 1'b0;
    end else begin
      hist <= irq_g;
      id_o <= win;
      irq_o <= win != '0;
      for (int k = 1; k <= IRQ_CNT; k++)
        case (st[k])
          IDLE: if (irq_g[k] && !(edge_i[k] && hist[k])) st[k] <= PEND;
          PEND: if (claim_i && id_o == ID_W'(k)) st[k] <= INFL;
          INFL: if (complete_i && complete_id_i == ID_W'(k)) st[k] <= IDLE;
          default: st[k] <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_plic_prio.sv
// tb_plic_prio: directed vector table plus randomized run against a reference model of plic_prio
module tb_plic_prio;
  localparam int N = 8, PW = 3, IW = 4;
`ifdef PLIC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, reset_n = 0;
  logic [N:1] irq = '0, ie = '1, edg = '0;
  logic [N*PW-1:0] prio = '0;
  logic [PW-1:0] thr = '0;
  logic claim = 0, complete = 0;
  logic [IW-1:0] cid = '0;
  logic irq_o;
  logic [IW-1:0] id_o;
  int checks = 0, errors = 0;
  plic_prio #(.IRQ_CNT(N), .PRIO_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .irq_i(irq), .ie_i(ie), .edge_i(edg), .prio_i(prio),
    .threshold_i(thr), .claim_i(claim), .complete_i(complete), .complete_id_i(cid),
    .irq_o(irq_o), .id_o(id_o));
  always #5 clk = ~clk;
  bit m_pend [1:N], m_infl [1:N];
  logic [N:1] m_hist, m_s1, m_s2;
  int m_id;
  function automatic int pr(int k);
    return int'(prio[k*PW-1 -: PW]);
  endfunction
  function automatic logic [N*PW-1:0] pv(int a, int b, int c, int d, int e, int f, int g, int h);
    return {3'(h), 3'(g), 3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction
  task automatic model_reset();
    for (int k = 1; k <= N; k++) begin
      m_pend[k] = 0;
      m_infl[k] = 0;
    end
    m_hist = '0;
    m_s1 = '0;
    m_s2 = '0;
    m_id = 0;
  endtask
  task automatic model_step();
    bit np [1:N], ni [1:N];
    logic [N:1] g;
    int best, nid;
    if (!reset_n) begin
      model_reset();
      return;
    end
`ifdef PLIC_SYNC_EN
    g = m_s2;
`else
    g = irq;
`endif
    best = -1;
    nid = 0;
    for (int k = 1; k <= N; k++)
      if (m_pend[k] && ie[k] && pr(k) > int'(thr) && !(claim && m_id == k) && pr(k) > best) best = pr(k);
    for (int k = N; k >= 1; k--)
      if (m_pend[k] && ie[k] && pr(k) > int'(thr) && !(claim && m_id == k) && pr(k) == best) nid = k;
    for (int k = 1; k <= N; k++) begin
      np[k] = m_pend[k];
      ni[k] = m_infl[k];
      if (!m_pend[k] && !m_infl[k] && g[k] && !(edg[k] && m_hist[k])) np[k] = 1;
      if (m_pend[k] && claim && m_id == k) begin
        np[k] = 0;
        ni[k] = 1;
      end
      if (m_infl[k] && complete && int'(cid) == k) ni[k] = 0;
    end
    m_pend = np;
    m_infl = ni;
    m_hist = g;
    m_s2 = m_s1;
    m_s1 = irq;
    m_id = nid;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    logic [N:1] irq, edg;
    logic [N*PW-1:0] prio;
    logic [PW-1:0] thr;
    logic claim, comp;
    logic [IW-1:0] cid;
    logic [IW-1:0] exp;
  } vec_t;
  vec_t tbl [$];
  function automatic void v(logic [N:1] i, logic [N:1] e, logic [N*PW-1:0] p, int t, bit cl, bit co, int c, int x);
    tbl.push_back('{i, e, p, PW'(t), cl, co, IW'(c), IW'(x)});
  endfunction
  initial begin
    logic [N*PW-1:0] pa, pb, pc, pd;
    pa = pv(0, 0, 5, 0, 0, 7, 0, 0);
    pb = pv(0, 5, 0, 5, 0, 0, 0, 0);
    pc = pv(0, 0, 0, 0, 3, 0, 0, 0);
    pd = pv(2, 0, 0, 0, 0, 0, 0, 0);
    v(8'h24, 0, pa, 4, 0, 0, 0, 0); v(8'h24, 0, pa, 4, 0, 0, 0, 6); v(0, 0, pa, 4, 1, 0, 0, 3);
    v(0, 0, pa, 5, 0, 0, 0, 0);     v(0, 0, pa, 4, 0, 0, 0, 3);     v(0, 0, pa, 4, 1, 0, 0, 0);
    v(0, 0, pa, 4, 0, 1, 6, 0);     v(0, 0, pa, 4, 0, 1, 3, 0);
    v(8'h0a, 0, pb, 4, 0, 0, 0, 0); v(0, 0, pb, 4, 0, 0, 0, 2);     v(0, 0, pb, 4, 1, 0, 0, 4);
    v(0, 0, pb, 4, 1, 0, 0, 0);     v(0, 0, pb, 4, 0, 1, 2, 0);     v(8'h02, 0, pb, 4, 0, 0, 0, 0);
    v(0, 0, pb, 4, 0, 0, 0, 2);     v(0, 0, pb, 4, 1, 1, 4, 0);     v(8'h08, 0, pb, 4, 0, 0, 0, 0);
    v(0, 0, pb, 4, 0, 0, 0, 4);     v(0, 0, pb, 4, 1, 0, 0, 0);     v(0, 0, pb, 4, 0, 1, 4, 0);
    v(0, 0, pb, 4, 0, 1, 2, 0);     v(0, 0, pb, 4, 0, 1, 7, 0);     v(0, 0, pb, 4, 1, 0, 0, 0);
    v(8'h10, 8'h10, pc, 0, 0, 0, 0, 0); v(0, 8'h10, pc, 0, 0, 0, 0, 5); v(0, 8'h10, pc, 0, 1, 0, 0, 0);
    v(8'h10, 8'h10, pc, 0, 0, 0, 0, 0); v(0, 8'h10, pc, 0, 0, 0, 0, 0); v(0, 8'h10, pc, 0, 0, 1, 5, 0);
    v(0, 8'h10, pc, 0, 0, 0, 0, 0);     v(8'h10, 8'h10, pc, 0, 0, 0, 0, 0); v(8'h10, 8'h10, pc, 0, 0, 0, 0, 5);
    v(8'h10, 8'h10, pc, 0, 1, 0, 0, 0); v(8'h10, 8'h10, pc, 0, 0, 1, 5, 0); v(8'h10, 8'h10, pc, 0, 0, 0, 0, 0);
    v(8'h10, 8'h10, pc, 0, 0, 0, 0, 0); v(0, 8'h10, pc, 0, 0, 0, 0, 0);
    v(8'h01, 0, pd, 0, 0, 0, 0, 0); v(8'h01, 0, pd, 0, 0, 0, 0, 1); v(8'h01, 0, pd, 0, 1, 0, 0, 0);
    v(8'h01, 0, pd, 0, 0, 1, 1, 0); v(8'h01, 0, pd, 0, 0, 0, 0, 0); v(8'h01, 0, pd, 0, 0, 0, 0, 1);
    v(8'h01, 0, pd, 0, 1, 0, 0, 0); v(0, 0, pd, 0, 0, 0, 0, 0);     v(0, 0, pd, 0, 0, 1, 1, 0);
    v(0, 0, pd, 0, 0, 0, 0, 0);     v(0, 0, pd, 0, 0, 0, 0, 0);
    irq = '1;
    prio = pv(1, 1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("reset_id", id_o, 0);
    chk("reset_irq", irq_o, 0);
    reset_n = 1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("release_id", id_o, (i == LAT) ? 1 : 0);
    end
    claim = 1;
    tick();
    claim = 0;
    chk("claim1_next_id", id_o, 2);
    reset_n = 0;
    #1;
    model_reset();
    chk("async_reset_id", id_o, 0);
    chk("async_reset_irq", irq_o, 0);
    irq = '0;
    tick();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", id_o, 0);
    end
`ifndef PLIC_SYNC_EN
    foreach (tbl[r]) begin
      irq = tbl[r].irq;
      edg = tbl[r].edg;
      prio = tbl[r].prio;
      thr = tbl[r].thr;
      claim = tbl[r].claim;
      complete = tbl[r].comp;
      cid = tbl[r].cid;
      tick();
      chk($sformatf("vec%0d_id", r), id_o, tbl[r].exp);
      chk($sformatf("vec%0d_irq", r), irq_o, tbl[r].exp != 0);
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      irq = N'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) ie = N'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) edg = N'($urandom);
      if ($urandom_range(0, 7) == 0) prio = (N*PW)'($urandom);
      if ($urandom_range(0, 7) == 0) thr = PW'($urandom_range(0, 3));
      claim = $urandom_range(0, 2) == 0;
      complete = $urandom_range(0, 2) == 0;
      cid = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(1, N));
      tick();
      chk("rand_id", id_o, m_id);
      chk("rand_irq", irq_o, m_id != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
